// File: rtl/decoded_instr_queue_pkg.sv
// Shared types for the decoded-instruction queue: the scoreboard entry it carries,
// the stored entry format and the default depth.
package decoded_instr_queue_pkg;

   localparam int unsigned DEC_QUEUE_DEPTH = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  trans_id;
      logic [3:0]  fu;
      logic [6:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] result;
      logic        use_imm;
   } scoreboard_entry_t;

   typedef struct packed {
      logic              is_ctrl;
      scoreboard_entry_t sbe;
   } dec_queue_entry_t;

endpackage

// File: rtl/decoded_instr_queue_ptr.sv
// Wrapping circular-buffer pointer with synchronous clear; clear beats increment.
module dec_queue_ptr #(
   parameter int unsigned W = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clear_i,
   input  logic         inc_i,
   output logic [W-1:0] ptr_o
);

   logic [W-1:0] ptr_d, ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (clear_i)    ptr_d = '0;
      else if (inc_i) ptr_d = ptr_q + W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/decoded_instr_queue.sv
// In-order FIFO between decoder and scoreboard, with optional same-cycle fall-through
// when empty and a count of stored control-flow entries.
module decoded_instr_queue
   import decoded_instr_queue_pkg::*;
#(
   parameter int unsigned DEPTH        = DEC_QUEUE_DEPTH,
   parameter bit          FALL_THROUGH = 1'b1,
   localparam int unsigned PW          = $clog2(DEPTH),
   localparam int unsigned CW          = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  scoreboard_entry_t decoded_instr_i,
   input  logic              decoded_is_ctrl_i,
   input  logic              decoded_valid_i,
   output logic              decoded_ready_o,
   output scoreboard_entry_t issue_instr_o,
   output logic              issue_is_ctrl_o,
   output logic              issue_valid_o,
   input  logic              issue_ack_i,
   output logic              ctrl_pending_o,
   output logic [CW-1:0]     count_o
);

   dec_queue_entry_t mem_d [DEPTH];
   dec_queue_entry_t mem_q [DEPTH];
   dec_queue_entry_t head;
   logic [CW-1:0]    count_d, count_q;
   logic [CW-1:0]    ctrl_cnt_d, ctrl_cnt_q;
   logic             flushed_d, flushed_q;
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic             empty, pop, pop_mem, push, bypass;

   dec_queue_ptr #(.W(PW)) u_rd_ptr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (flush_i),
      .inc_i   (pop_mem),
      .ptr_o   (rd_ptr)
   );

   dec_queue_ptr #(.W(PW)) u_wr_ptr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (flush_i),
      .inc_i   (push),
      .ptr_o   (wr_ptr)
   );

   always_comb begin
      empty           = (count_q == '0);
      decoded_ready_o = (count_q != CW'(DEPTH)) && !flush_i;
      head            = mem_q[rd_ptr];

      // flushed_q holds fall-through off for the cycle following a flush or reset
      if (!empty) begin
         issue_instr_o   = head.sbe;
         issue_is_ctrl_o = head.is_ctrl;
         issue_valid_o   = !flush_i;
      end else begin
         issue_instr_o   = decoded_instr_i;
         issue_is_ctrl_o = decoded_is_ctrl_i;
         issue_valid_o   = FALL_THROUGH && decoded_valid_i && !flush_i && !flushed_q;
      end

      pop     = issue_valid_o && issue_ack_i && !flush_i;
      bypass  = FALL_THROUGH && empty && pop;
      push    = decoded_valid_i && decoded_ready_o && !bypass;
      pop_mem = pop && !empty;

      mem_d = mem_q;
      if (push) mem_d[wr_ptr] = '{is_ctrl: decoded_is_ctrl_i, sbe: decoded_instr_i};

      flushed_d = flush_i;
      if (flush_i) begin
         count_d    = '0;
         ctrl_cnt_d = '0;
      end else begin
         count_d    = count_q + CW'(push) - CW'(pop_mem);
         ctrl_cnt_d = ctrl_cnt_q + CW'(push && decoded_is_ctrl_i)
                                 - CW'(pop_mem && head.is_ctrl);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q    <= '0;
         ctrl_cnt_q <= '0;
         flushed_q  <= 1'b1;
      end else begin
         count_q    <= count_d;
         ctrl_cnt_q <= ctrl_cnt_d;
         flushed_q  <= flushed_d;
      end
   end

   // Payloads are never cleared; only the pointers and counts reset.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   assign count_o        = count_q;
   assign ctrl_pending_o = (ctrl_cnt_q != '0);

   a_count_range : assert property (@(posedge clk_i) disable iff (rst_i)
      (count_q <= CW'(DEPTH)) && (ctrl_cnt_q <= count_q));
   a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(push && !pop_mem && count_q == CW'(DEPTH)));
   a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(pop_mem && empty));
   a_issue_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (issue_valid_o && !issue_ack_i && !flush_i) |=> $stable(issue_instr_o));

endmodule

// File: tb/tb_decoded_instr_queue.sv
// Directed bench for decoded_instr_queue (DEPTH=4, FALL_THROUGH=1).
module tb_decoded_instr_queue;
   import decoded_instr_queue_pkg::*;

   logic              clk = 1'b0;
   logic              rst, flush, vin, is_ctrl, ack;
   scoreboard_entry_t din;
   logic              ready, iss_ctrl, iss_valid, ctrl_pending;
   scoreboard_entry_t iss_instr;
   logic [2:0]        count;
   int                errors = 0;
   int                checks = 0;

   always #5 clk = ~clk;

   decoded_instr_queue #(.DEPTH(4), .FALL_THROUGH(1'b1)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .flush_i           (flush),
      .decoded_instr_i   (din),
      .decoded_is_ctrl_i (is_ctrl),
      .decoded_valid_i   (vin),
      .decoded_ready_o   (ready),
      .issue_instr_o     (iss_instr),
      .issue_is_ctrl_o   (iss_ctrl),
      .issue_valid_o     (iss_valid),
      .issue_ack_i       (ack),
      .ctrl_pending_o    (ctrl_pending),
      .count_o           (count)
   );

   function automatic scoreboard_entry_t mk(input int id);
      scoreboard_entry_t s;
      s          = '0;
      s.pc       = 32'h1000 + 32'(id) * 4;
      s.trans_id = 3'(id);
      s.op       = 7'(id);
      s.rd       = 5'(id);
      s.result   = 32'(id) ^ 32'hA5A5_0000;
      return s;
   endfunction

   // Advance one edge and settle; inputs are changed only after this returns.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      vin = 0; is_ctrl = 0; ack = 0; flush = 0; din = '0;
   endtask

   task automatic chk_count(input string name, input int exp);
      checks++;
      if (count !== 3'(exp)) begin
         errors++;
         $display("FAIL %s: count_o=%0d expected %0d", name, count, exp);
      end
   endtask

   task automatic chk_head(input string name, input int id);
      checks++;
      if (iss_valid !== 1'b1 || iss_instr !== mk(id)) begin
         errors++;
         $display("FAIL %s: valid=%b pc=%h expected valid=1 pc=%h", name, iss_valid,
                  iss_instr.pc, mk(id).pc);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic push_n(input int first, input int n, input logic ctrl);
      for (int k = 0; k < n; k++) begin
         vin = 1; din = mk(first + k); is_ctrl = ctrl; ack = 0;
         tick();
      end
      idle();
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      tick(); tick();
      #1;
      chk_count("reset_count", 0);
      chk_bit("reset_valid", iss_valid, 1'b0);
      chk_bit("reset_ctrl_pending", ctrl_pending, 1'b0);
      chk_bit("reset_ready", ready, 1'b1);
      rst = 0;
      tick();
   endtask

   task automatic test_fill();
      for (int k = 0; k < 4; k++) begin
         vin = 1; din = mk(k); is_ctrl = 0; ack = 0;
         tick();
         chk_count($sformatf("fill_count%0d", k), k + 1);
         chk_head($sformatf("fill_head%0d", k), 0);
      end
      idle(); #1;
      chk_bit("fill_ready_full", ready, 1'b0);
   endtask

   task automatic test_drain();
      ack = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk_head($sformatf("drain_head%0d", k), k);
         tick();
         chk_count($sformatf("drain_count%0d", k), 3 - k);
      end
      ack = 0; #1;
      chk_bit("drain_valid_after", iss_valid, 1'b0);
   endtask

   task automatic test_fall_through();
      vin = 1; din = mk(20); is_ctrl = 1; ack = 1;
      #1;
      chk_head("ft_same_cycle", 20);
      chk_bit("ft_ctrl_flag", iss_ctrl, 1'b1);
      tick();
      idle(); #1;
      chk_count("ft_count", 0);
      chk_bit("ft_ctrl_untouched", ctrl_pending, 1'b0);
      chk_bit("ft_valid_after", iss_valid, 1'b0);
   endtask

   task automatic test_back_to_back();
      push_n(30, 2, 1'b0);
      #1;
      chk_count("b2b_start", 2);
      for (int k = 0; k < 6; k++) begin
         vin = 1; din = mk(32 + k); is_ctrl = 0; ack = 1;
         #1;
         chk_head($sformatf("b2b_head%0d", k), 30 + k);
         tick();
         chk_count($sformatf("b2b_count%0d", k), 2);
      end
      vin = 0; ack = 1;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk_head($sformatf("b2b_tail%0d", k), 36 + k);
         tick();
      end
      idle(); #1;
      chk_count("b2b_end", 0);
   endtask

   task automatic test_full_refuse();
      push_n(40, 4, 1'b0);
      vin = 1; din = mk(99); ack = 1;
      #1;
      chk_bit("full_pop_ready", ready, 1'b0);
      tick();
      vin = 0;
      chk_count("full_pop_count", 3);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk_head($sformatf("full_pop_order%0d", k), 41 + k);
         tick();
      end
      idle(); #1;
      chk_count("full_pop_end", 0);
   endtask

   task automatic test_flush();
      push_n(50, 2, 1'b1);
      push_n(52, 1, 1'b0);
      #1;
      chk_count("flush_pre_count", 3);
      chk_bit("flush_pre_pending", ctrl_pending, 1'b1);
      flush = 1; vin = 1; din = mk(60); is_ctrl = 1; ack = 1;
      #1;
      chk_bit("flush_cycle_valid", iss_valid, 1'b0);
      chk_bit("flush_cycle_ready", ready, 1'b0);
      tick();
      flush = 0; vin = 1; din = mk(61); is_ctrl = 0; ack = 0;
      #1;
      chk_count("flush_count", 0);
      chk_bit("flush_pending", ctrl_pending, 1'b0);
      chk_bit("flush_after_valid", iss_valid, 1'b0);
      vin = 0;
      tick();
      chk_count("flush_input_dropped", 0);
   endtask

   task automatic test_ctrl_pending();
      push_n(70, 2, 1'b1);
      push_n(72, 1, 1'b0);
      #1;
      chk_bit("ctrl_after_push", ctrl_pending, 1'b1);
      ack = 1;
      chk_head("ctrl_head0", 70);
      tick();
      chk_bit("ctrl_after_pop1", ctrl_pending, 1'b1);
      chk_head("ctrl_head1", 71);
      tick();
      chk_bit("ctrl_after_pop2", ctrl_pending, 1'b0);
      chk_head("ctrl_head2", 72);
      tick();
      idle(); #1;
      chk_count("ctrl_end", 0);
   endtask

   task automatic test_reset_mid();
      push_n(80, 2, 1'b1);
      rst = 1;
      tick();
      rst = 0; #1;
      chk_count("rst_mid_count", 0);
      chk_bit("rst_mid_valid", iss_valid, 1'b0);
      chk_bit("rst_mid_pending", ctrl_pending, 1'b0);
      tick();
   endtask

   initial begin
      rst = 1;
      idle();
      test_reset();
      test_fill();
      test_drain();
      test_fall_through();
      test_back_to_back();
      test_full_refuse();
      test_flush();
      test_ctrl_pending();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected finish before 100000");
      $fatal(1);
   end

endmodule
